// File: rtl/load_store_aligner_pkg.sv
// Shared encodings for the load/store alignment unit: access sizes, FSM states,
// and the lane-index width helper used by the top and the lane extractor.
package load_store_aligner_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // Bits needed to index a byte lane inside a DW-bit word.
    function automatic int lane_w(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/load_store_aligner_lane_extract.sv
// Combinational lane selector: pulls the addressed byte/half/word/double out of a
// memory word, extends it, and produces the matching per-lane byte-enable mask.
module lane_extract
    import load_store_aligner_pkg::*;
#(
    parameter  int DW = 32,
    localparam int LW = lane_w(DW),
    localparam int NB = DW / 8
) (
    input  logic [DW-1:0] i_word,
    input  logic [LW-1:0] i_offset,
    input  logic [1:0]    i_size,
    input  logic          i_unsigned,
    output logic [DW-1:0] o_value,
    output logic [NB-1:0] o_be
);

    logic [DW-1:0] w_shift;
    logic [DW-1:0] w_keep;
    logic [NB-1:0] w_lanes;
    logic          w_sign;

    assign w_shift = i_word >> {i_offset, 3'b000};

    always_comb begin
        w_keep  = '1;
        w_lanes = '1;
        w_sign  = w_shift[DW-1];
        case (i_size)
            SZ_BYTE: begin
                w_keep  = DW'(8'hFF);
                w_lanes = NB'(1'b1);
                w_sign  = w_shift[7];
            end
            SZ_HALF: begin
                w_keep  = DW'(16'hFFFF);
                w_lanes = NB'(2'b11);
                w_sign  = w_shift[15];
            end
            SZ_WORD: begin
                w_keep  = DW'(32'hFFFF_FFFF);
                w_lanes = NB'(4'hF);
                w_sign  = w_shift[31];
            end
            default: begin
                w_keep  = '1;
                w_lanes = '1;
                w_sign  = w_shift[DW-1];
            end
        endcase
    end

    // Sign fill only touches the bits above the selected field.
    assign o_value = (w_shift & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);
    assign o_be    = w_lanes << i_offset;

endmodule

// File: rtl/load_store_aligner.sv
// Load/store alignment unit: aligns loads, merges sub-word stores by
// read-modify-write, flags misaligned accesses, and sequences a fixed-latency memory.
module load_store_aligner
    import load_store_aligner_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_misalign,
    output state_e        dbg_state
);

    localparam int LW = lane_w(DW);
    localparam int NB = DW / 8;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and rsp_valid is a single-cycle pulse with no stall.
    state_e        r_state;
    state_e        w_next;
    logic [2:0]    r_cnt;
    logic          r_store;
    logic          r_unsigned;
    logic          r_mis;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    logic          w_accept;
    logic          w_mis;
    logic          w_full;
    logic          w_last;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_ext;
    logic [NB-1:0] w_be;
    logic [DW-1:0] w_bmask;
    logic [DW-1:0] w_wshift;
    logic [DW-1:0] w_merged;

    assign w_accept  = req_valid && req_ready;
    assign w_full    = (DW == 32) ? (req_size == SZ_WORD) : (req_size == SZ_DOUBLE);
    assign w_last    = (r_cnt == 3'(MEM_LAT - 1));
    assign w_waddr   = {r_addr[AW-1:LW], {LW{1'b0}}};
    assign dbg_state = r_state;

    always_comb begin
        w_mis = 1'b0;
        case (req_size)
            SZ_BYTE: w_mis = 1'b0;
            SZ_HALF: w_mis = req_addr[0];
            SZ_WORD: w_mis = |req_addr[1:0];
            default: w_mis = (DW == 32) || (|req_addr[2:0]);
        endcase
    end

    lane_extract #(.DW(DW)) u_lane (
        .i_word     (mem_rdata),
        .i_offset   (r_addr[LW-1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_value    (w_ext),
        .o_be       (w_be)
    );

    // The load byte-enables double as the store merge mask.
    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < NB; i++) begin
            w_bmask[8*i +: 8] = {8{w_be[i]}};
        end
    end

    assign w_wshift = r_data << {r_addr[LW-1:0], 3'b000};
    assign w_merged = (mem_rdata & ~w_bmask) | (w_wshift & w_bmask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        rsp_valid    = 1'b0;
        rsp_misalign = 1'b0;
        rsp_rdata    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_mis) begin
                        w_next = ST_RESP;
                    end else if (req_store && w_full) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_rd   = 1'b1;
                mem_addr = w_waddr;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_last) begin
                    w_next = r_store ? ST_WR : ST_RESP;
                end
            end
            ST_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = w_waddr;
                mem_wdata = r_data;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                rsp_misalign = r_mis;
                rsp_rdata    = (r_store || r_mis) ? '0 : r_data;
                w_next       = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_RD) begin
            r_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // r_data first holds the store data, then is replaced by the load result or merged word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_mis      <= 1'b0;
            r_size     <= SZ_BYTE;
            r_addr     <= '0;
            r_data     <= '0;
        end else if (w_accept) begin
            r_store    <= req_store;
            r_unsigned <= req_unsigned;
            r_mis      <= w_mis;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_data     <= req_wdata;
        end else if (r_state == ST_WAIT && w_last) begin
            r_data <= r_store ? w_merged : w_ext;
        end
    end

endmodule
